// File: rtl/fpgasynth_nios2_dbg_ocimem_pkg.sv
// Shared definitions for the debug-monitor memory engine: jdo field offsets,
// the pending-op type and the memory FSM states.
package fpgasynth_dbg_pkg;
  localparam int JDO_W            = 38;
  localparam int ADDR_LSB         = 17;
  localparam int WDATA_LSB        = 3;
  localparam int RD_AFTER_SET_BIT = 35;
  localparam int CLR_ERR_BIT      = 36;

  typedef enum logic [1:0] {NONE, RD, WR} op_t;
  typedef enum logic [1:0] {IDLE, J_RD, C_RD} state_t;
endpackage

// File: rtl/fpgasynth_nios2_dbg_ocimem_if.sv
// RAM port plus CPU Avalon-MM debug slave, bundled as one bus.
// slave = the ocimem engine, master = the RAM/CPU environment.
interface fpgasynth_nios2_dbg_ocimem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  mem_rdata, avs_address, avs_read, avs_write, avs_writedata,
    output mem_addr, mem_wdata, mem_wr, mem_rd, avs_readdata, avs_waitrequest
  );
  modport master (
    output mem_rdata, avs_address, avs_read, avs_write, avs_writedata,
    input  mem_addr, mem_wdata, mem_wr, mem_rd, avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/fpgasynth_nios2_dbg_ocimem_cmdq.sv
// JTAG command front end: strobe priority decode, 1-deep pending-op hold,
// and the sticky overrun error.
module fpgasynth_nios2_dbg_ocimem_cmdq
  import fpgasynth_dbg_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              done,
  output op_t               hold_op,
  output logic [DATA_W-1:0] hold_data,
  output logic              error
);
  op_t  req_op;
  logic drop;
  logic overrun;

  // Bits 37 and 2:0 of jdo carry nothing for this engine.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1], jdo[WDATA_LSB-1:0]};

  // Priority decode: ocimem_a > no_action_a > ocimem_b; losers are dropped.
  always_comb begin
    req_op = NONE;
    drop   = 1'b0;
    if (take_action_ocimem_a) begin
      if (jdo[RD_AFTER_SET_BIT]) req_op = RD;
      drop = take_no_action_ocimem_a | take_action_ocimem_b;
    end else if (take_no_action_ocimem_a) begin
      req_op = RD;
      drop   = take_action_ocimem_b;
    end else if (take_action_ocimem_b) begin
      req_op = WR;
    end
  end

  // Anything arriving while an op is still held is lost.
  assign overrun = (req_op != NONE) && (hold_op != NONE);

  // Hold register and sticky error; a new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_op   <= NONE;
      hold_data <= '0;
      error     <= 1'b0;
    end else begin
      if (done) begin
        hold_op <= NONE;
      end else if (req_op != NONE && hold_op == NONE) begin
        hold_op   <= req_op;
        hold_data <= jdo[WDATA_LSB +: DATA_W];
      end
      if (drop || overrun)
        error <= 1'b1;
      else if (take_action_ocimem_a && jdo[CLR_ERR_BIT])
        error <= 1'b0;
    end
  end
endmodule

// File: rtl/fpgasynth_nios2_dbg_ocimem.sv
// Debug-monitor memory engine: executes held JTAG ops against the debug RAM
// and arbitrates the same RAM with the CPU debug slave (JTAG first).
module fpgasynth_nios2_dbg_ocimem
  import fpgasynth_dbg_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  fpgasynth_nios2_dbg_ocimem_if.slave bus
);
  state_t            state, state_n;
  op_t               hold_op;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_q;
  logic              done, addr_inc;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              mem_wr_c, mem_rd_c, wait_c;

  fpgasynth_nios2_dbg_ocimem_cmdq #(.DATA_W(DATA_W)) u_cmdq (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .done                    (done),
    .hold_op                 (hold_op),
    .hold_data               (hold_data),
    .error                   (monitor_error)
  );

  // Next-state and RAM/CPU strobes; a held JTAG op always beats the CPU.
  always_comb begin
    state_n     = state;
    mem_addr_c  = addr;
    mem_wdata_c = hold_data;
    mem_wr_c    = 1'b0;
    mem_rd_c    = 1'b0;
    wait_c      = 1'b1;
    done        = 1'b0;
    addr_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_op == WR) begin
          mem_wr_c = 1'b1;
          done     = 1'b1;
          addr_inc = 1'b1;
        end else if (hold_op == RD) begin
          mem_rd_c = 1'b1;
          state_n  = J_RD;
        end else if (bus.avs_write) begin
          mem_addr_c  = bus.avs_address;
          mem_wdata_c = bus.avs_writedata;
          mem_wr_c    = 1'b1;
          wait_c      = 1'b0;
        end else if (bus.avs_read) begin
          mem_addr_c = bus.avs_address;
          mem_rd_c   = 1'b1;
          state_n    = C_RD;
        end
      end
      J_RD: begin
        done     = 1'b1;
        addr_inc = 1'b1;
        state_n  = IDLE;
      end
      C_RD: begin
        wait_c  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (reset) begin
      state_n  = IDLE;
      mem_wr_c = 1'b0;
      mem_rd_c = 1'b0;
      wait_c   = 1'b1;
      done     = 1'b0;
      addr_inc = 1'b0;
    end
  end

  // State, JTAG address pointer (set beats increment) and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      MonDReg <= '0;
      rd_q    <= '0;
    end else begin
      state <= state_n;
      if (take_action_ocimem_a)
        addr <= jdo[ADDR_LSB +: ADDR_W];
      else if (addr_inc)
        addr <= addr + ADDR_W'(1);
      if (state == J_RD) MonDReg <= bus.mem_rdata;
      if (state == C_RD) rd_q    <= bus.mem_rdata;
    end
  end

  // Read data is presented in the same cycle waitrequest drops, then held.
  assign bus.avs_readdata    = reset ? '0 : ((state == C_RD) ? bus.mem_rdata : rd_q);
  assign bus.avs_waitrequest = wait_c;
  assign bus.mem_addr        = mem_addr_c;
  assign bus.mem_wdata       = mem_wdata_c;
  assign bus.mem_wr          = mem_wr_c;
  assign bus.mem_rd          = mem_rd_c;
  assign monitor_ready       = reset | (hold_op == NONE);
endmodule

// File: tb/tb_fpgasynth_nios2_dbg_ocimem.sv
// Directed bench for the debug-monitor memory engine with a behavioural RAM.
module tb_fpgasynth_nios2_dbg_ocimem;
  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ram [256];

  fpgasynth_nios2_dbg_ocimem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  fpgasynth_nios2_dbg_ocimem #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .bus                     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid one clock after mem_rd.
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic jset(input logic [7:0] a, input logic rd, input logic clr);
    jdo = mk_a(a, rd, clr);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jwrite(input logic [31:0] d);
    jdo = mk_b(d);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
  endtask

  task automatic jread();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_wait", bus.avs_waitrequest, 1);
    chk("rst_wr", bus.mem_wr, 0);
    chk("rst_rd", bus.mem_rd, 0);
    reset = 1'b0;
    tick(); settle();
    chk("rst_mon", MonDReg, 0);
    chk("rst_ready", monitor_ready, 1);
    chk("rst_err", monitor_error, 0);
    chk("rst_rdata", bus.avs_readdata, 0);
    chk("rst_addr", bus.mem_addr, 0);

    // 1: set address then JTAG write
    jset(8'h10, 1'b0, 1'b0);
    jdo = mk_b(32'hDEADBEEF);
    take_action_ocimem_b = 1'b1;
    settle();
    chk("t1_ready_pre", monitor_ready, 1);
    tick();
    take_action_ocimem_b = 1'b0;
    settle();
    chk("t1_wr", bus.mem_wr, 1);
    chk("t1_addr", bus.mem_addr, 8'h10);
    chk("t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t1_ready_busy", monitor_ready, 0);
    tick(); settle();
    chk("t1_ready_after", monitor_ready, 1);
    chk("t1_wr_off", bus.mem_wr, 0);
    chk("t1_next_addr", bus.mem_addr, 8'h11);

    // 2: set-address with read-after-set
    jset(8'h10, 1'b0, 1'b0);
    jwrite(32'hCAFEF00D);
    jdo = mk_a(8'h10, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    settle();
    chk("t2_rd", bus.mem_rd, 1);
    chk("t2_rd_addr", bus.mem_addr, 8'h10);
    chk("t2_ready_busy", monitor_ready, 0);
    tick(); settle();
    chk("t2_mon_pending", MonDReg, 0);
    chk("t2_rd_off", bus.mem_rd, 0);
    tick(); settle();
    chk("t2_mon", MonDReg, 32'hCAFEF00D);
    chk("t2_ready", monitor_ready, 1);
    chk("t2_addr", bus.mem_addr, 8'h11);

    // 3: reads across the address wrap
    jset(8'hFF, 1'b0, 1'b0);
    jwrite(32'h11111111);
    jwrite(32'h22222222);
    jset(8'hFF, 1'b0, 1'b0);
    jread(); settle();
    chk("t3_mon_ff", MonDReg, 32'h11111111);
    chk("t3_addr_wrap", bus.mem_addr, 8'h00);
    jread(); settle();
    chk("t3_mon_00", MonDReg, 32'h22222222);
    chk("t3_addr_final", bus.mem_addr, 8'h01);

    // 4: CPU read behind a JTAG write, then a CPU write
    jset(8'h05, 1'b0, 1'b0);
    jwrite(32'h55555555);
    jdo = mk_b(32'h77777777);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    bus.avs_address = 8'h05;
    bus.avs_read = 1'b1;
    settle();
    chk("t4_jwr", bus.mem_wr, 1);
    chk("t4_jaddr", bus.mem_addr, 8'h06);
    chk("t4_wait1", bus.avs_waitrequest, 1);
    tick(); settle();
    chk("t4_crd", bus.mem_rd, 1);
    chk("t4_caddr", bus.mem_addr, 8'h05);
    chk("t4_wait2", bus.avs_waitrequest, 1);
    tick(); settle();
    chk("t4_wait3", bus.avs_waitrequest, 0);
    chk("t4_rdata", bus.avs_readdata, 32'h55555555);
    bus.avs_read = 1'b0;
    tick(); settle();
    chk("t4_rdata_hold", bus.avs_readdata, 32'h55555555);
    chk("t4_wait_idle", bus.avs_waitrequest, 1);
    chk("t4_jaddr_after", bus.mem_addr, 8'h07);
    bus.avs_address = 8'h20;
    bus.avs_writedata = 32'hA5A5A5A5;
    bus.avs_write = 1'b1;
    settle();
    chk("t4_cwr", bus.mem_wr, 1);
    chk("t4_cwait", bus.avs_waitrequest, 0);
    chk("t4_cwaddr", bus.mem_addr, 8'h20);
    chk("t4_cwdata", bus.mem_wdata, 32'hA5A5A5A5);
    tick();
    bus.avs_write = 1'b0;

    // 5: overrun and priority drops set a sticky error
    take_no_action_ocimem_a = 1'b1;
    tick();
    tick();
    take_no_action_ocimem_a = 1'b0;
    settle();
    chk("t5_err_ovr", monitor_error, 1);
    tick(); settle();
    chk("t5_ready_ovr", monitor_ready, 1);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    jdo = mk_a(8'h40, 1'b1, 1'b0);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    tick(); settle();
    chk("t5_set_addr_kept", bus.mem_addr, 8'h41);
    chk("t5_rd_dropped", monitor_ready, 1);
    chk("t5_err_sticky", monitor_error, 1);
    jset(8'h30, 1'b0, 1'b1);
    settle();
    chk("t5_err_clr", monitor_error, 0);
    chk("t5_addr_30", bus.mem_addr, 8'h30);
    jdo = mk_a(8'h30, 1'b0, 1'b0);
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    settle();
    chk("t5_err_sim", monitor_error, 1);
    chk("t5_b_dropped", bus.mem_wr, 0);
    chk("t5_ready_sim", monitor_ready, 1);
    tick(); tick(); settle();
    chk("t5_err_hold", monitor_error, 1);
    jset(8'h30, 1'b0, 1'b1);
    settle();
    chk("t5_err_clr2", monitor_error, 0);

    // 6: reset during a JTAG read
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    settle();
    chk("t6_rd", bus.mem_rd, 1);
    tick();
    reset = 1'b1;
    settle();
    chk("t6_rst_rd", bus.mem_rd, 0);
    chk("t6_rst_wait", bus.avs_waitrequest, 1);
    tick();
    reset = 1'b0;
    settle();
    chk("t6_mon", MonDReg, 0);
    chk("t6_ready", monitor_ready, 1);
    chk("t6_rd_off", bus.mem_rd, 0);
    chk("t6_wait", bus.avs_waitrequest, 1);
    tick(); settle();
    chk("t6_mon_late", MonDReg, 0);
    chk("t6_ready_late", monitor_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
